cond_fork_n: RTL

COND_FORK_N -- requirements
Module: cond_fork_n

---
 rtl/cond_fork_n.sv | 112 +++++++++++
 1 files changed

// File: rtl/cond_fork_n.sv
// Conditional fork: one upstream request fans out to the branches selected by
// valid, then frees upstream when any or all of them return (FREE_MODE).
module cond_fork_n #(
    parameter int unsigned N         = 3,
    parameter int unsigned FREE_MODE = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_drive,
    output logic             o_free,
    input  logic [N-1:0]     valid,
    output logic [N-1:0]     o_driveNext,
    input  logic [N-1:0]     i_freeNext,
    output logic             o_busy,
    output logic             o_overrun,
    input  logic             i_clr_overrun,
    output logic [CNT_W-1:0] o_txn_cnt,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_WAIT     = 2'd2,
        ST_FREE     = 2'd3
    } state_t;

    // Handshake: i_drive is a one-cycle request accepted only in IDLE; o_free
    // is a one-cycle completion pulse; branches see one-cycle o_driveNext
    // pulses and answer on i_freeNext (level or pulse), masked by P.
    state_t             r_state;
    logic [N-1:0]       r_pend;
    logic [N-1:0]       r_drive_next;
    logic               r_free;
    logic               r_busy;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_txn_cnt;

    logic [N-1:0]       w_pend_left;
    logic               w_done;
    logic               w_drive_busy;

    assign w_pend_left  = r_pend & ~i_freeNext;
    assign w_done       = (FREE_MODE != 0) ? (w_pend_left == '0)
                                           : ((r_pend & i_freeNext) != '0);
    assign w_drive_busy = i_drive && (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_pend       <= '0;
            r_drive_next <= '0;
            r_free       <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            r_txn_cnt    <= '0;
        end else begin
            r_drive_next <= '0;
            r_free       <= 1'b0;
            // A new overrun beats a simultaneous clear.
            if (w_drive_busy)
                r_overrun <= 1'b1;
            else if (i_clr_overrun)
                r_overrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_drive) begin
                        r_pend <= valid;
                        r_busy <= 1'b1;
                        if (valid != '0) begin
                            r_state      <= ST_DISPATCH;
                            r_drive_next <= valid;
                        end else begin
                            r_state   <= ST_FREE;
                            r_free    <= 1'b1;
                            r_txn_cnt <= r_txn_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DISPATCH, ST_WAIT: begin
                    if (w_done) begin
                        // In any-mode the stragglers are dropped by clearing P.
                        r_state   <= ST_FREE;
                        r_free    <= 1'b1;
                        r_pend    <= '0;
                        r_txn_cnt <= r_txn_cnt + CNT_W'(1);
                    end else begin
                        r_state <= ST_WAIT;
                        r_pend  <= w_pend_left;
                    end
                end
                ST_FREE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_free      = r_free;
    assign o_driveNext = r_drive_next;
    assign o_busy      = r_busy;
    assign o_overrun   = r_overrun;
    assign o_txn_cnt   = r_txn_cnt;
    assign o_state     = r_state;

endmodule
